fpu_issuer: RTL

//  Initiator side of the fpu en/fi handshake: accepts operand sets a/b/c/d from an upstream

---
 rtl/fpu_pkg.sv | 13 +
 rtl/fpu_issuer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the fpu issuer: datapath width and FSM state encoding.
package fpu_pkg;

   localparam int FPU_W = 32;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_DRAIN = 2'd1;
   localparam state_t ST_ISSUE = 2'd2;
   localparam state_t ST_RESP  = 2'd3;

endpackage : fpu_pkg

// File: rtl/fpu_issuer.sv
// Initiator side of the fpu en/fi handshake. Takes an operand set from a
// valid/ready request port, holds fpu_en with stable operands until fi, then
// presents the result on a valid/ready response port. A watchdog aborts an
// fpu that never answers; done_cnt counts every completed op (ok or aborted).
module fpu_issuer
   import fpu_pkg::*;
#(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [FPU_W-1:0] req_a,
   input  logic [FPU_W-1:0] req_b,
   input  logic [FPU_W-1:0] req_c,
   input  logic [FPU_W-1:0] req_d,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [FPU_W-1:0] rsp_g,
   output logic             rsp_err,
   output logic             fpu_en,
   input  logic             fpu_fi,
   output logic [FPU_W-1:0] fpu_a,
   output logic [FPU_W-1:0] fpu_b,
   output logic [FPU_W-1:0] fpu_c,
   output logic [FPU_W-1:0] fpu_d,
   input  logic [FPU_W-1:0] fpu_g,
   output logic             busy,
   output logic [CNT_W-1:0] done_cnt
);

   // Watchdog counts ISSUE cycles 0..TIMEOUT-1; hitting the last value with fi low aborts.
   localparam int              WD_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam bit              WD_EN  = (TIMEOUT > 0);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

   state_t           state_q,     state_d;
   logic             fpu_en_q,    fpu_en_d;
   logic [FPU_W-1:0] fpu_a_q,     fpu_a_d;
   logic [FPU_W-1:0] fpu_b_q,     fpu_b_d;
   logic [FPU_W-1:0] fpu_c_q,     fpu_c_d;
   logic [FPU_W-1:0] fpu_d_q,     fpu_d_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [FPU_W-1:0] rsp_g_q,     rsp_g_d;
   logic             rsp_err_q,   rsp_err_d;
   logic [CNT_W-1:0] done_cnt_q,  done_cnt_d;
   logic [WD_W-1:0]  wd_q,        wd_d;
   logic             wd_hit_s;

   assign wd_hit_s = WD_EN && (wd_q == WD_MAX);

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; a stale fi at accept is drained before issuing.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               state_d = fpu_fi ? ST_DRAIN : ST_ISSUE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (!fpu_fi) begin
               state_d = ST_ISSUE;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         ST_ISSUE: begin
            if (fpu_fi || wd_hit_s) begin
               state_d = ST_RESP;
            end else begin
               state_d = ST_ISSUE;
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output/datapath next values; fi takes priority over a same-cycle timeout.
   always_comb begin
      fpu_a_d     = fpu_a_q;
      fpu_b_d     = fpu_b_q;
      fpu_c_d     = fpu_c_q;
      fpu_d_d     = fpu_d_q;
      rsp_g_d     = rsp_g_q;
      rsp_err_d   = rsp_err_q;
      done_cnt_d  = done_cnt_q;
      wd_d        = {WD_W{1'b0}};
      fpu_en_d    = (state_d == ST_ISSUE);
      rsp_valid_d = (state_d == ST_RESP);
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               fpu_a_d = req_a;
               fpu_b_d = req_b;
               fpu_c_d = req_c;
               fpu_d_d = req_d;
            end else begin
               fpu_a_d = fpu_a_q;
            end
         end
         ST_ISSUE: begin
            if (fpu_fi) begin
               rsp_g_d   = fpu_g;
               rsp_err_d = 1'b0;
            end else if (wd_hit_s) begin
               rsp_g_d   = {FPU_W{1'b0}};
               rsp_err_d = 1'b1;
            end else begin
               wd_d = WD_EN ? (wd_q + WD_W'(1)) : {WD_W{1'b0}};
            end
         end
         ST_RESP: begin
            if (rsp_ready) begin
               done_cnt_d = done_cnt_q + CNT_W'(1);
            end else begin
               done_cnt_d = done_cnt_q;
            end
         end
         default: begin
            wd_d = {WD_W{1'b0}};
         end
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fpu_en_q    <= 1'b0;
         fpu_a_q     <= {FPU_W{1'b0}};
         fpu_b_q     <= {FPU_W{1'b0}};
         fpu_c_q     <= {FPU_W{1'b0}};
         fpu_d_q     <= {FPU_W{1'b0}};
         rsp_valid_q <= 1'b0;
         rsp_g_q     <= {FPU_W{1'b0}};
         rsp_err_q   <= 1'b0;
         done_cnt_q  <= {CNT_W{1'b0}};
         wd_q        <= {WD_W{1'b0}};
      end else begin
         fpu_en_q    <= fpu_en_d;
         fpu_a_q     <= fpu_a_d;
         fpu_b_q     <= fpu_b_d;
         fpu_c_q     <= fpu_c_d;
         fpu_d_q     <= fpu_d_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_g_q     <= rsp_g_d;
         rsp_err_q   <= rsp_err_d;
         done_cnt_q  <= done_cnt_d;
         wd_q        <= wd_d;
      end
   end

   assign req_ready = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign fpu_en    = fpu_en_q;
   assign fpu_a     = fpu_a_q;
   assign fpu_b     = fpu_b_q;
   assign fpu_c     = fpu_c_q;
   assign fpu_d     = fpu_d_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_g     = rsp_g_q;
   assign rsp_err   = rsp_err_q;
   assign done_cnt  = done_cnt_q;

endmodule : fpu_issuer
